// File: rtl/inst_sequencer.sv
// Opcode register, T-cycle counter and interrupt arbitration in front of the 6502 decoder.
// Optional macro IRQ_LATCH_EN: sticky per-source IRQ pend bits instead of level-sensitive IRQ.
module inst_sequencer #(
  parameter int unsigned CYC_W = 3,
  parameter int unsigned NIRQ  = 4,
  parameter int unsigned OPW   = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [OPW-1:0]   dbus,
  input  logic             icyc,
  input  logic             rcyc,
  input  logic [NIRQ-1:0]  irq_src,
  input  logic             iflag,
  input  logic             nmi,
  output logic [OPW-1:0]   inst,
  output logic [CYC_W-1:0] cycle,
  output logic [1:0]       cause,
  output logic [7:0]       vec_lo,
  output logic [2:0]       irq_id,
  output logic [NIRQ-1:0]  irq_ack,
  output logic             seq_err
);

  typedef enum logic [1:0] {
    CAUSE_NONE = 2'b00,
    CAUSE_RST  = 2'b01,
    CAUSE_NMI  = 2'b10,
    CAUSE_IRQ  = 2'b11
  } cause_e;

  localparam logic [7:0]       VEC_RST = 8'hFC;
  localparam logic [7:0]       VEC_NMI = 8'hFA;
  localparam logic [7:0]       VEC_IRQ = 8'hFE;
  localparam logic [CYC_W-1:0] CYC_MAX = '1;

  logic [OPW-1:0]   inst_q, inst_d;
  logic [CYC_W-1:0] cycle_q, cycle_d;
  cause_e           cause_q, cause_d;
  logic [7:0]       vec_lo_q, vec_lo_d;
  logic [2:0]       irq_id_q, irq_id_d;
  logic [NIRQ-1:0]  irq_ack_q, irq_ack_d;
  logic             seq_err_q, seq_err_d;
  logic             nmi_q, nmi_pend_q, nmi_pend_d;

  logic [NIRQ-1:0]  irq_pend_c;
  logic [NIRQ-1:0]  grant_c;
  logic [2:0]       irq_sel_c;
  logic             irq_req_c;
  logic             nmi_edge_c;

`ifdef IRQ_LATCH_EN
  logic [NIRQ-1:0]  irq_pend_q, irq_pend_d;
  // A source raised in the dispatch cycle itself is visible without waiting for the latch.
  assign irq_pend_c = irq_pend_q | irq_src;
`else
  assign irq_pend_c = irq_src;
`endif

  // Lowest set index wins; only the registered NMI pend bit is dispatched.
  always_comb begin
    irq_sel_c = 3'd0;
    for (int i = int'(NIRQ) - 1; i >= 0; i--) begin
      if (irq_pend_c[i]) irq_sel_c = 3'(i);
    end
    grant_c    = NIRQ'(1) << irq_sel_c;
    irq_req_c  = (|irq_pend_c) & ~iflag;
    nmi_edge_c = nmi & ~nmi_q;

    inst_d     = inst_q;
    cycle_d    = cycle_q;
    cause_d    = cause_q;
    vec_lo_d   = vec_lo_q;
    irq_id_d   = irq_id_q;
    irq_ack_d  = '0;
    seq_err_d  = seq_err_q;
    nmi_pend_d = nmi_pend_q | nmi_edge_c;
`ifdef IRQ_LATCH_EN
    irq_pend_d = irq_pend_q | irq_src;
`endif

    if (rcyc) begin
      cycle_d = '0;
      if (nmi_pend_q) begin
        inst_d     = '0;
        cause_d    = CAUSE_NMI;
        vec_lo_d   = VEC_NMI;
        nmi_pend_d = nmi_edge_c;
      end else if (irq_req_c) begin
        inst_d    = '0;
        cause_d   = CAUSE_IRQ;
        vec_lo_d  = VEC_IRQ;
        irq_id_d  = irq_sel_c;
        irq_ack_d = grant_c;
`ifdef IRQ_LATCH_EN
        irq_pend_d = (irq_pend_q & ~grant_c) | irq_src;
`endif
      end else begin
        inst_d   = dbus;
        cause_d  = CAUSE_NONE;
        vec_lo_d = VEC_IRQ;
      end
    end else if (icyc) begin
      if (cycle_q == CYC_MAX) begin
        seq_err_d = 1'b1;
      end else begin
        cycle_d = cycle_q + CYC_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      inst_q     <= '0;
      cycle_q    <= '0;
      cause_q    <= CAUSE_RST;
      vec_lo_q   <= VEC_RST;
      irq_id_q   <= 3'd0;
      irq_ack_q  <= '0;
      seq_err_q  <= 1'b0;
      nmi_q      <= 1'b0;
      nmi_pend_q <= 1'b0;
`ifdef IRQ_LATCH_EN
      irq_pend_q <= '0;
`endif
    end else begin
      inst_q     <= inst_d;
      cycle_q    <= cycle_d;
      cause_q    <= cause_d;
      vec_lo_q   <= vec_lo_d;
      irq_id_q   <= irq_id_d;
      irq_ack_q  <= irq_ack_d;
      seq_err_q  <= seq_err_d;
      nmi_q      <= nmi;
      nmi_pend_q <= nmi_pend_d;
`ifdef IRQ_LATCH_EN
      irq_pend_q <= irq_pend_d;
`endif
    end
  end

  assign inst    = inst_q;
  assign cycle   = cycle_q;
  assign cause   = cause_q;
  assign vec_lo  = vec_lo_q;
  assign irq_id  = irq_id_q;
  assign irq_ack = irq_ack_q;
  assign seq_err = seq_err_q;

endmodule
